// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS core.
package mips_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer with one-deep branch delay slot.
module pc_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [XLEN-1:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pcnext,
    input  logic            redirect,
    input  logic            instr_ready,
    input  logic            imem_waitrequest,
    input  logic [XLEN-1:0] imem_readdata,
    output logic [XLEN-1:0] imem_address,
    output logic            imem_read,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic            active,
    output logic            fault
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            pending;
    logic [XLEN-1:0] pend_target;

    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] npc;
    logic            accept;
    logic            instr_load;
    logic            pend_set;
    logic            pend_clr;
    logic            fault_set;

    // The fetch address is always the architectural PC.
    assign imem_address = pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= START;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-PC and register-update strobes.
    always_comb begin
        state_next = state;
        pc_seq     = pc + XLEN'(INSTR_BYTES);
        npc        = pc_seq;
        accept     = 1'b0;
        instr_load = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        fault_set  = 1'b0;
        case (state)
            START: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (!imem_waitrequest) begin
                    instr_load = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    accept = 1'b1;
                    // A redirect inside a delay slot is dropped.
                    if (pending) begin
                        npc      = pend_target;
                        pend_clr = 1'b1;
                    end else if (redirect) begin
                        pend_set = 1'b1;
                    end
                    if (npc == HALT_ADDR) begin
                        state_next = HALTED;
                    end else if (npc[1:0] != 2'b00) begin
                        fault_set  = 1'b1;
                        state_next = HALTED;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = START;
            end
        endcase
    end

    // Status outputs registered from the next state so they track the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_read   <= 1'b0;
            instr_valid <= 1'b0;
            active      <= 1'b1;
        end else begin
            imem_read   <= (state_next == FETCH);
            instr_valid <= (state_next == ISSUE);
            active      <= (state_next != HALTED);
        end
    end

    // PC, instruction, delayed-branch target and sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VECTOR;
            instr       <= '0;
            pending     <= 1'b0;
            pend_target <= '0;
            fault       <= 1'b0;
        end else begin
            if (accept) begin
                pc <= npc;
            end
            if (instr_load) begin
                instr <= imem_readdata;
            end
            if (pend_set) begin
                pending     <= 1'b1;
                pend_target <= pcnext;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

endmodule : pc_fetch

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, wait states, delay slot, stalls, halt, fault, reset.
module tb_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcnext;
    logic        redirect;
    logic        instr_ready;
    logic        imem_waitrequest;
    logic [31:0] imem_readdata;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        active;
    logic        fault;

    int unsigned n_checks;
    int unsigned n_pass;

    logic        use_mem;
    logic [31:0] rd_word;

    pc_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pcnext           (pcnext),
        .redirect         (redirect),
        .instr_ready      (instr_ready),
        .imem_waitrequest (imem_waitrequest),
        .imem_readdata    (imem_readdata),
        .imem_address     (imem_address),
        .imem_read        (imem_read),
        .pc               (pc),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .active           (active),
        .fault            (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign imem_readdata = use_mem ? mem_fn(imem_address) : rd_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Assert reset, check reset outputs, release on a falling edge; returns in FETCH.
    task automatic do_reset();
        rst_n            = 1'b0;
        redirect         = 1'b0;
        pcnext           = '0;
        instr_ready      = 1'b1;
        imem_waitrequest = 1'b0;
        use_mem          = 1'b1;
        rd_word          = '0;
        @(negedge clk);
        check("rst_read",   32'(imem_read),   32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_active", 32'(active),      32'd1);
        check("rst_fault",  32'(fault),       32'd0);
        check("rst_pc",     pc,               32'hBFC0_0000);
        check("rst_instr",  instr,            32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One fetch + issue with zero wait and immediate ready; redirect/pcnext applied on accept.
    task automatic run_instr(input logic [31:0] exp_pc, input logic redir, input logic [31:0] tgt);
        check("fetch_read", 32'(imem_read), 32'd1);
        check("fetch_addr", imem_address,   exp_pc);
        redirect = redir;
        pcnext   = tgt;
        @(negedge clk);
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_pc",    pc,               exp_pc);
        check("issue_instr", instr,            mem_fn(exp_pc));
        check("issue_noread", 32'(imem_read),  32'd0);
        @(negedge clk);
        redirect = 1'b0;
        pcnext   = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n            = 1'b0;
        redirect         = 1'b0;
        pcnext           = '0;
        instr_ready      = 1'b1;
        imem_waitrequest = 1'b0;
        use_mem          = 1'b1;
        rd_word          = '0;

        // Sequential fetch, 2 cycles per instruction, nothing issued in START.
        do_reset();
        check("seq_start_novalid", 32'(instr_valid), 32'd0);
        run_instr(32'hBFC0_0000, 1'b0, '0);
        run_instr(32'hBFC0_0004, 1'b0, '0);
        run_instr(32'hBFC0_0008, 1'b0, '0);
        run_instr(32'hBFC0_000C, 1'b0, '0);

        // Branch at BFC00010: delay slot, then target; redirect in slot dropped.
        run_instr(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
        run_instr(32'hBFC0_0014, 1'b1, 32'h1234_5678);
        run_instr(32'hBFC0_0100, 1'b0, '0);

        // Execute stall for 5 cycles in ISSUE.
        check("stall_fetch_addr", imem_address, 32'hBFC0_0104);
        instr_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc",    pc,               32'hBFC0_0104);
            check("stall_instr", instr,            mem_fn(32'hBFC0_0104));
            check("stall_noread", 32'(imem_read),  32'd0);
        end
        instr_ready = 1'b1;
        @(negedge clk);

        // JR to 0: delay slot fetched, then halted for good.
        run_instr(32'hBFC0_0108, 1'b1, 32'h0000_0000);
        run_instr(32'hBFC0_010C, 1'b0, '0);
        check("halt_active", 32'(active),      32'd0);
        check("halt_pc",     pc,               32'h0000_0000);
        check("halt_fault",  32'(fault),       32'd0);
        for (int i = 0; i < 8; i++) begin
            check("halt_noread",  32'(imem_read),   32'd0);
            check("halt_novalid", 32'(instr_valid), 32'd0);
            @(negedge clk);
        end

        // Misaligned target: fault after the delay slot.
        do_reset();
        run_instr(32'hBFC0_0000, 1'b1, 32'hBFC0_0102);
        run_instr(32'hBFC0_0004, 1'b0, '0);
        check("fault_flag",   32'(fault),     32'd1);
        check("fault_active", 32'(active),    32'd0);
        check("fault_pc",     pc,             32'hBFC0_0102);
        check("fault_noread", 32'(imem_read), 32'd0);

        // Wait states on the first fetch: address held 4 cycles, release-cycle data captured.
        do_reset();
        use_mem          = 1'b0;
        imem_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wait_read", 32'(imem_read), 32'd1);
            check("wait_addr", imem_address,   32'hBFC0_0000);
            rd_word = 32'hA000_0000 + 32'(i);
            if (i == 3) imem_waitrequest = 1'b0;
            @(negedge clk);
        end
        check("wait_valid", 32'(instr_valid), 32'd1);
        check("wait_instr", instr,            32'hA000_0003);
        use_mem = 1'b1;
        @(negedge clk);

        // Reset during a stalled fetch with a pending redirect.
        do_reset();
        run_instr(32'hBFC0_0000, 1'b1, 32'hBFC0_0200);
        imem_waitrequest = 1'b1;
        @(negedge clk);
        check("midrst_pre_read", 32'(imem_read), 32'd1);
        check("midrst_pre_addr", imem_address,   32'hBFC0_0004);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_read",   32'(imem_read),   32'd0);
        check("midrst_valid",  32'(instr_valid), 32'd0);
        check("midrst_active", 32'(active),      32'd1);
        check("midrst_pc",     pc,               32'hBFC0_0000);
        imem_waitrequest = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_instr(32'hBFC0_0000, 1'b0, '0);
        run_instr(32'hBFC0_0004, 1'b0, '0);
        check("midrst_no_pending", imem_address, 32'hBFC0_0008);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_fetch

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the multicycle MIPS core. It holds the architectural PC and fetches instructions over the Avalon-style instruction bus. It presents each instruction, with its PC, to decode/execute and consumes `pcnext`/`redirect` from the next-PC logic, deferring taken branches and jumps by one instruction to implement the MIPS branch delay slot. It also detects the halt condition (control transfer to address 0) and misaligned fetches.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC0_0000: PC value loaded at reset.
- `HALT_ADDR`, 32'h0000_0000: target address that stops the core.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pcnext` in 32: target from next-PC logic, valid while `instr_valid`.
- `redirect` in 1: current instruction transfers control (branch taken, J/JAL/JR/JALR); sampled on the accept cycle.
- `instr_ready` in 1: execute accepts the presented instruction.
- `imem_waitrequest` in 1: bus stall.
- `imem_readdata` in 32: instruction word.
- `imem_address` out 32: fetch address (= `pc`).
- `imem_read` out 1: bus read request.
- `pc` out 32: PC of the presented instruction; also feeds next-PC logic.
- `instr` out 32: registered instruction word.
- `instr_valid` out 1: `instr`/`pc` valid for execute.
- `active` out 1: core running; low once halted or faulted.
- `fault` out 1: sticky misaligned-fetch flag.

## Operation
- States: START, FETCH, ISSUE, HALTED.
- START: one cycle after reset release, then go to FETCH. No bus request.
- FETCH: `imem_read`=1 and `imem_address`=`pc`, held stable while `imem_waitrequest`=1. When `imem_waitrequest`=0, latch `imem_readdata` into `instr` and go to ISSUE.
- ISSUE: `instr_valid`=1. `instr` and `pc` are held until `instr_ready`=1 (accept). On accept, compute the next fetch PC `npc`:
  - If `pending`=1, `npc`=`pend_target` and `pending` is cleared. `redirect` is ignored here (branch in a delay slot is architecturally undefined and is dropped).
  - Else if `redirect`=1, `pend_target`<=`pcnext`, `pending`<=1, and `npc`=`pc`+4 (the delay slot).
  - Else `npc`=`pc`+4. The addition is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- After accept: `pc`<=`npc`.
  - If `npc`==`HALT_ADDR`, go to HALTED.
  - Else if `npc[1:0]`!=0, set `fault` and go to HALTED.
  - Else go to FETCH.
- HALTED: terminal until reset. `active`=0, no bus requests, `instr_valid`=0, and `pc` holds the halt/fault address.
- `active`=1 in START, FETCH and ISSUE.
- `RESET_VECTOR` is word-aligned by definition and is not checked.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state START, `pc`=`RESET_VECTOR`, `instr`=0, `pending`=0, `pend_target`=0.
  - Outputs: `imem_read`=0, `instr_valid`=0, `active`=1, `fault`=0.
- `imem_read`, `instr_valid` and `active` decode from state only. They never combinationally depend on `instr_ready` or `imem_waitrequest`.
- Minimum throughput is 2 cycles per instruction: FETCH with zero wait, then ISSUE with immediate ready. Each bus wait cycle and each `instr_ready`=0 cycle adds one cycle.
- `instr_ready` has no effect outside ISSUE.
- `imem_waitrequest` has no effect outside FETCH.
- `pc` changes only on the cycle following an accept.
- Reset asserted mid-fetch or mid-issue aborts immediately. The outstanding read is abandoned (the bus tolerates `imem_read` dropping during reset). No pending redirect survives reset.

## Structure
- Shared `mips_pkg` holds:
  - `fetch_state_t` (START, FETCH, ISSUE, HALTED)
  - `RESET_VECTOR_DEFAULT`, `HALT_ADDR_DEFAULT`
  - `INSTR_BYTES` (=4)
- Single module with one state register, the `pc`, `instr`, `pending` and `pend_target` registers, and one combinational `npc`/next-state block. No sub-module is warranted.

## Test plan
- Reset, 0 wait states, `instr_ready` tied 1, no redirect:
  - `imem_address` sequence is BFC00000, BFC00004, BFC00008.
  - `instr_valid` pulses every 2nd cycle.
  - Nothing is issued in the START cycle.
- `imem_waitrequest` held 3 cycles on the first fetch:
  - Address stays BFC00000 with `imem_read`=1 for 4 cycles.
  - `instr` equals the readdata from the release cycle.
- Branch at BFC00010 accepted with `redirect`=1, `pcnext`=BFC00100:
  - Next fetches are BFC00014 (delay slot), then BFC00100.
  - `redirect`=1 on the delay-slot accept is ignored.
- `instr_ready` low 5 cycles in ISSUE: `instr`, `pc` and `instr_valid` are stable, and no bus read occurs.
- JR with `pcnext`=0:
  - The delay slot is fetched.
  - Then `active`=0, `pc`=0, and `imem_read` stays 0 forever.
  - `pcnext`=BFC00102 instead → `fault`=1, `active`=0.
- `rst_n` pulsed low during FETCH wait, with a pending redirect:
  - Outputs go to reset values asynchronously.
  - After release, the first fetch is BFC00000, not the pending target.
